// File: rtl/carry_select_adder.sv
// -----------------------------------------------------------------------------
// carry_select_adder
//   Registered WIDTH-bit carry-select adder built from BLOCK_W-bit segments.
//   Every segment computes two ripple-carry sums in parallel: one that assumes
//   an incoming carry equal to cin1, and one that assumes cin0. A select chain
//   then picks one result per segment. Segment 0 is selected by cin. Each later
//   segment is selected by the carry chosen for the segment below it. The sum
//   and the final carry are registered, so the stage has one cycle of latency.
//
// Parameters
//   WIDTH    operand / sum width; must be a multiple of BLOCK_W
//   BLOCK_W  segment width
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset (clears sum and cout)
//   a      in   WIDTH  operand A, unsigned
//   b      in   WIDTH  operand B, unsigned
//   cin    in   1      select for segment 0 (1 -> cin1 result, 0 -> cin0 result)
//   cin1   in   1      carry assumed by every segment's "carry=1" precompute
//   cin0   in   1      carry assumed by every segment's "carry=0" precompute
//   sum    out  WIDTH  registered sum
//   cout   out  1      registered carry of the most significant segment
// -----------------------------------------------------------------------------
module carry_select_adder #(
    parameter int WIDTH   = 4,
    parameter int BLOCK_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             cin1,
    input  logic             cin0,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSEG = WIDTH / BLOCK_W;

    // BLOCK_W-bit ripple-carry add. The result is {carry_out, sum}.
    function automatic logic [BLOCK_W:0] ripple_add(
        input logic [BLOCK_W-1:0] x,
        input logic [BLOCK_W-1:0] y,
        input logic               c
    );
        logic               carry_v;
        logic [BLOCK_W-1:0] s_v;
        carry_v = c;
        s_v     = {BLOCK_W{1'b0}};
        for (int i = 0; i < BLOCK_W; i++) begin
            s_v[i]  = x[i] ^ y[i] ^ carry_v;
            carry_v = (x[i] & y[i]) | (carry_v & (x[i] ^ y[i]));
        end
        return {carry_v, s_v};
    endfunction

    logic [BLOCK_W:0] res1_s [NSEG];
    logic [BLOCK_W:0] res0_s [NSEG];
    logic [BLOCK_W:0] chosen_s;
    logic             sel_s;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Both speculative results for each segment, formed in parallel ahead of the select chain
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        assign res1_s[k] = ripple_add(a[k*BLOCK_W +: BLOCK_W], b[k*BLOCK_W +: BLOCK_W], cin1);
        assign res0_s[k] = ripple_add(a[k*BLOCK_W +: BLOCK_W], b[k*BLOCK_W +: BLOCK_W], cin0);
    end

    // Select chain: the carry chosen for segment k-1 picks the result of segment k
    always_comb begin
        sum_d    = {WIDTH{1'b0}};
        chosen_s = {(BLOCK_W+1){1'b0}};
        sel_s    = cin;
        for (int k = 0; k < NSEG; k++) begin
            if (sel_s) begin
                chosen_s = res1_s[k];
            end else begin
                chosen_s = res0_s[k];
            end
            sum_d[k*BLOCK_W +: BLOCK_W] = chosen_s[BLOCK_W-1:0];
            sel_s                       = chosen_s[BLOCK_W];
        end
        cout_d = sel_s;
    end

    // Output register. Reset clears it at once and drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= {WIDTH{1'b0}};
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_carry_select_adder.sv
module tb_carry_select_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a4, b4, sum4;
    logic       cin4, cin0_4, cin1_4, cout4;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cin0_8, cin1_8, cout8;

    int errors;
    int checks;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       cin0;
        logic       cin1;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec4_t;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       cin0;
        logic       cin1;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec8_t;

    vec4_t v4[10];
    vec8_t v8[5];

    carry_select_adder #(.WIDTH(4), .BLOCK_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4),
        .cin1(cin1_4), .cin0(cin0_4), .sum(sum4), .cout(cout4)
    );

    carry_select_adder #(.WIDTH(8), .BLOCK_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
        .cin1(cin1_8), .cin0(cin0_8), .sum(sum8), .cout(cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {cout,sum}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic c0, input logic c1);
        a4 = a; b4 = b; cin4 = c; cin0_4 = c0; cin1_4 = c1;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Hand-computed 4-bit vectors
        v4[0] = '{"add_0011_1010",      4'h3, 4'hA, 1'b0, 1'b0, 1'b1, 4'hD, 1'b0};
        v4[1] = '{"add_0111_1110",      4'h7, 4'hE, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1};
        v4[2] = '{"cin1_0001_1011",     4'h1, 4'hB, 1'b1, 1'b0, 1'b1, 4'hD, 1'b0};
        v4[3] = '{"cin1_0011_1110",     4'h3, 4'hE, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1};
        v4[4] = '{"wrap_ones",          4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1};
        v4[5] = '{"zeros",              4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
        v4[6] = '{"nonstd_c0eq1",       4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1};
        v4[7] = '{"nonstd_sel1_c1eq0",  4'h5, 4'h6, 1'b1, 1'b1, 1'b0, 4'hB, 1'b0};
        v4[8] = '{"both_carries_one",   4'h8, 4'h7, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1};
        v4[9] = '{"both_carries_zero",  4'h9, 4'h9, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1};

        // Hand-computed 8-bit, two-segment vectors
        v8[0] = '{"w8_cross_boundary",  8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
        v8[1] = '{"w8_plain",           8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0};
        v8[2] = '{"w8_cin_wrap",        8'h80, 8'h80, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1};
        v8[3] = '{"w8_nonstd_chain",    8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        v8[4] = '{"w8_low_carry_in",    8'h0F, 8'hF0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1};

        // Reset asserted with no clock edge: outputs must be zero immediately
        rst_n = 1'b1;
        drive4(4'hA, 4'h7, 1'b1, 1'b0, 1'b1);
        a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1; cin0_8 = 1'b0; cin1_8 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_immediate_4", {cout4, sum4}, 9'h000);
        check("reset_immediate_8", {cout8, sum8}, 9'h000);
        @(posedge clk); @(posedge clk); #1;
        check("reset_hold_4", {cout4, sum4}, 9'h000);
        check("reset_hold_8", {cout8, sum8}, 9'h000);

        @(negedge clk);
        rst_n = 1'b1;

        // Table for the 4-bit adder: apply on the falling edge, check 1 after the rising edge
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive4(v4[i].a, v4[i].b, v4[i].cin, v4[i].cin0, v4[i].cin1);
            @(posedge clk); #1;
            check(v4[i].name, {cout4, sum4}, {1'b0, v4[i].exp_cout, v4[i].exp_sum});
        end

        // Table for the 8-bit adder
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a8 = v8[i].a; b8 = v8[i].b; cin8 = v8[i].cin;
            cin0_8 = v8[i].cin0; cin1_8 = v8[i].cin1;
            @(posedge clk); #1;
            check(v8[i].name, {cout8, sum8}, {v8[i].exp_cout, v8[i].exp_sum});
        end

        // Result must hold until the next edge even though the inputs change
        @(negedge clk);
        drive4(4'h7, 4'hE, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive4(4'h1, 4'h1, 1'b0, 1'b0, 1'b1);
        #2;
        check("hold_between_edges", {cout4, sum4}, 9'h015);

        // Mid-stream reset between edges, then release: next edge shows current inputs
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midstream_reset_clear", {cout4, sum4}, 9'h000);
        drive4(4'h4, 4'h4, 1'b1, 1'b0, 1'b1);
        #1;
        rst_n = 1'b1;
        #1;
        check("released_before_edge", {cout4, sum4}, 9'h000);
        @(posedge clk); #1;
        check("first_edge_after_release", {cout4, sum4}, 9'h009);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before limit");
        $fatal(1);
    end

endmodule
